// File: rtl/mips_instr_encoder.sv
// ============================================================================
// mips_instr_encoder : encodes op-level requests into MIPS words, buffers them
// in a FIFO and writes them sequentially to instruction memory.
// Optional feature macro: INSTR_ENC_SLT_EN (op 7 encodes slt when defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              err,
  output logic [15:0]       words_written
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [15:0]       ww_q;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;

  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              accept;
  logic              push;
  logic              pop;

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    case (in_op)
      3'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'h20};
      3'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'h22};
      3'd2: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'h24};
      3'd3: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'h25};
      3'd4: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd5: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd6: enc_word = {6'b000100, in_rs, in_rt, in_imm};
      default: begin
`ifdef INSTR_ENC_SLT_EN
        enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'h2A};
`else
        enc_ok   = 1'b0;
`endif
      end
    endcase
  end

  // Readiness comes from registered occupancy only, so a pop in the same
  // cycle never frees a slot for a push.
  assign in_ready = (count_q != C_FULL);
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc_ok;
  assign pop      = (state_q == ST_WRITE) && imem_ack;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      ww_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept && !enc_ok) begin
        err_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            wdata_q <= mem_q[rd_ptr_q];
            we_q    <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            we_q    <= 1'b0;
            addr_q  <= addr_q + ADDR_W'(4);
            if (ww_q != 16'hFFFF) begin
              ww_q <= ww_q + 16'd1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
// ============================================================================
// tb_mips_instr_encoder : scoreboard bench for mips_instr_encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_instr_encoder;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [15:0] in_imm = '0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ack = 1'b0;
  logic        err;
  logic [15:0] words_written;

  mips_instr_encoder #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_imm       (in_imm),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_ack     (imem_ack),
    .err          (err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] next_addr = BASE;
  int          exp_ww = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void enc(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm,
                              output logic [31:0] w, output logic ok);
    ok = 1'b1;
    w  = '0;
    case (op)
      3'd0: w = {6'd0, rs, rt, rd, 5'd0, 6'h20};
      3'd1: w = {6'd0, rs, rt, rd, 5'd0, 6'h22};
      3'd2: w = {6'd0, rs, rt, rd, 5'd0, 6'h24};
      3'd3: w = {6'd0, rs, rt, rd, 5'd0, 6'h25};
      3'd4: w = {6'b100011, rs, rt, imm};
      3'd5: w = {6'b101011, rs, rt, imm};
      3'd6: w = {6'b000100, rs, rt, imm};
      default: begin
`ifdef INSTR_ENC_SLT_EN
        w = {6'd0, rs, rt, rd, 5'd0, 6'h2A};
`else
        ok = 1'b0;
`endif
      end
    endcase
  endfunction

  // Monitor: every acknowledged write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && imem_we && imem_ack) begin
      chk("write_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wdata", 64'(imem_wdata), 64'(e.data));
        chk("addr", 64'(imem_addr), 64'(e.addr));
        exp_ww++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
    logic [31:0] w;
    logic        ok;
    int          n;
    enc(op, rs, rt, rd, imm, w, ok);
    in_valid = 1'b1;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    if (in_ready && ok) begin
      sb.push_back('{addr: next_addr, data: w});
      next_addr = next_addr + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_addr, first_data;
    logic        exp_err;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'(BASE));
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ww", 64'(words_written), 64'd0);
    rst = 1'b0;

    // Single add with ack tied high.
    imem_ack = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    drain("drain_add");
    chk("ww_add", 64'(words_written), 64'd1);

    // lw / sw / beq sequence.
    send(3'd4, 5'd9, 5'd8, 5'd0, 16'h0004);
    send(3'd5, 5'd6, 5'd5, 5'd0, 16'h0008);
    send(3'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF);
    drain("drain_mem");
    chk("ww_mem", 64'(words_written), 64'(exp_ww));

    // Remaining R-types; the first of these crosses the address wrap.
    send(3'd1, 5'd31, 5'd0, 5'd17, 16'h0);
    send(3'd2, 5'd4, 5'd5, 5'd6, 16'h0);
    send(3'd3, 5'd10, 5'd20, 5'd30, 16'h0);
    drain("drain_rtype");
    chk("addr_wrapped", 64'(imem_addr), 64'd12);
    chk("ww_rtype", 64'(words_written), 64'(exp_ww));

    // Fill the FIFO with ack held low.
    imem_ack = 1'b0;
    send(3'd0, 5'd7, 5'd8, 5'd9, 16'h0);
    send(3'd4, 5'd3, 5'd2, 5'd0, 16'h1234);
    send(3'd5, 5'd12, 5'd13, 5'd0, 16'h8000);
    send(3'd1, 5'd14, 5'd15, 5'd16, 16'h0);
    first_addr = sb[0].addr;
    first_data = sb[0].data;
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_we", 64'(imem_we), 64'd1);
    chk("full_addr", 64'(imem_addr), 64'(first_addr));
    chk("full_wdata", 64'(imem_wdata), 64'(first_data));
    in_valid = 1'b1;
    in_op = 3'd3;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stable_ready", 64'(in_ready), 64'd0);
    chk("stable_addr", 64'(imem_addr), 64'(first_addr));
    chk("stable_wdata", 64'(imem_wdata), 64'(first_data));
    imem_ack = 1'b1;
    drain("drain_full");
    chk("full_ready_back", 64'(in_ready), 64'd1);
    chk("ww_full", 64'(words_written), 64'(exp_ww));

    // Op 7: slt when enabled, otherwise consumed with err set.
`ifdef INSTR_ENC_SLT_EN
    exp_err = 1'b0;
`else
    exp_err = 1'b1;
`endif
    send(3'd7, 5'd1, 5'd2, 5'd3, 16'h0);
    drain("drain_op7");
    chk("op7_err", 64'(err), 64'(exp_err));
    chk("ww_op7", 64'(words_written), 64'(exp_ww));

    // Reset while a write is outstanding with three words queued.
    imem_ack = 1'b0;
    send(3'd0, 5'd1, 5'd1, 5'd1, 16'h0);
    send(3'd2, 5'd2, 5'd2, 5'd2, 16'h0);
    send(3'd3, 5'd3, 5'd3, 5'd3, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_we", 64'(imem_we), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_we", 64'(imem_we), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_addr", 64'(imem_addr), 64'(BASE));
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_ww", 64'(words_written), 64'd0);
    sb.delete();
    next_addr = BASE;
    exp_ww = 0;
    rst = 1'b0;
    imem_ack = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_we", 64'(imem_we), 64'd0);
    chk("post_rst_ww", 64'(words_written), 64'd0);

    send(3'd6, 5'd21, 5'd22, 5'd0, 16'h00AA);
    drain("drain_post_rst");
    chk("ww_post_rst", 64'(words_written), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
